// File: rtl/fix2single_arb_pkg.sv
// Shared constants and stage record for the two-requester fixed-point to
// IEEE 754 single converter.
package fix2single_arb_pkg;

  localparam int unsigned FLOAT_BIAS    = 127;
  localparam int unsigned MANT_WIDTH    = 23;
  localparam int unsigned EXP_WIDTH     = 8;
  localparam int unsigned PAYLOAD_WIDTH = 1 + EXP_WIDTH + MANT_WIDTH;

  // Payload holds the zero-extended operand in S1 and the float in S2.
  typedef struct packed {
    logic                     valid;
    logic                     tag;
    logic [PAYLOAD_WIDTH-1:0] payload;
  } stage_t;

endpackage

// File: rtl/fix2single_core.sv
// Combinational conversion halves: leading-zero count (feeds S1) and float
// assembly from a registered operand plus its count (feeds S2).
module fix2single_core
  import fix2single_arb_pkg::*;
#(
  parameter  int unsigned INT_WIDTH   = 12,
  parameter  int unsigned FRACT_WIDTH = 4,
  localparam int unsigned W           = INT_WIDTH + FRACT_WIDTH,
  localparam int unsigned LZ_WIDTH    = $clog2(W)
) (
  input  logic [W-1:0]             lzc_operand,
  output logic [LZ_WIDTH-1:0]      lzc_count,
  input  logic [PAYLOAD_WIDTH-1:0] asm_operand,
  input  logic [LZ_WIDTH-1:0]      asm_lz,
  output logic [PAYLOAD_WIDTH-1:0] asm_result
);

  logic                 found;
  logic [W-1:0]         norm;
  logic [EXP_WIDTH-1:0] exp_field;
  logic [MANT_WIDTH-1:0] mant;

  // Priority scan from the MSB; a zero operand leaves the count at 0.
  always_comb begin
    lzc_count = '0;
    found     = 1'b0;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      if (!found && lzc_operand[i]) begin
        lzc_count = LZ_WIDTH'(int'(W) - 1 - i);
        found     = 1'b1;
      end
    end
  end

  // Leading one lands on the hidden bit and is dropped; mantissa is truncated.
  always_comb begin
    norm       = W'(asm_operand << asm_lz);
    mant       = MANT_WIDTH'(32'(norm) << (MANT_WIDTH + 1 - W));
    exp_field  = EXP_WIDTH'(int'(FLOAT_BIAS + INT_WIDTH) - 1 - int'(asm_lz));
    asm_result = (asm_operand == '0) ? '0 : {1'b0, exp_field, mant};
  end

endmodule

// File: rtl/fix2single_arb.sv
// Round-robin arbiter in front of a two-stage fixed-point to single-precision
// converter with valid/ready flow control on both sides.
module fix2single_arb
  import fix2single_arb_pkg::*;
#(
  parameter  int unsigned INT_WIDTH   = 12,
  parameter  int unsigned FRACT_WIDTH = 4,
  localparam int unsigned W           = INT_WIDTH + FRACT_WIDTH,
  localparam int unsigned LZ_WIDTH    = $clog2(W)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_data,
  output logic         req1_ready,
  output logic         out_valid,
  output logic [31:0]  out_data,
  output logic         out_tag,
  input  logic         out_ready
);

  stage_t                   s1_q;
  stage_t                   s2_q;
  logic [LZ_WIDTH-1:0]      s1_lz_q;
  logic                     last_q;

  logic                     s2_load;
  logic                     s1_open;
  logic                     grant0;
  logic                     grant1;
  logic                     xfer0;
  logic                     xfer1;
  logic                     xfer_any;
  logic [W-1:0]             operand_c;
  logic [LZ_WIDTH-1:0]      lz_c;
  logic [PAYLOAD_WIDTH-1:0] result_c;

  fix2single_core #(
    .INT_WIDTH   (INT_WIDTH),
    .FRACT_WIDTH (FRACT_WIDTH)
  ) u_core (
    .lzc_operand (operand_c),
    .lzc_count   (lz_c),
    .asm_operand (s1_q.payload),
    .asm_lz      (s1_lz_q),
    .asm_result  (result_c)
  );

  // Flow control and arbitration; ready is masked while reset is held.
  always_comb begin
    s2_load    = !s2_q.valid || out_ready;
    s1_open    = !s1_q.valid || s2_load;
    grant0     = req0_valid && (!req1_valid || last_q);
    grant1     = req1_valid && (!req0_valid || !last_q);
    req0_ready = rst_n && s1_open && grant0;
    req1_ready = rst_n && s1_open && grant1;
    xfer0      = req0_valid && req0_ready;
    xfer1      = req1_valid && req1_ready;
    xfer_any   = xfer0 || xfer1;
    operand_c  = xfer1 ? req1_data : req0_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      s1_lz_q <= '0;
      last_q  <= 1'b1;
    end else begin
      if (s2_load) begin
        s2_q <= '{valid: s1_q.valid, tag: s1_q.tag, payload: result_c};
      end
      if (s1_open) begin
        s1_q    <= '{valid: xfer_any, tag: xfer1, payload: PAYLOAD_WIDTH'(operand_c)};
        s1_lz_q <= lz_c;
      end
      if (xfer_any) begin
        last_q <= xfer1;
      end
    end
  end

  assign out_valid = s2_q.valid;
  assign out_data  = s2_q.payload;
  assign out_tag   = s2_q.tag;

endmodule

// File: tb/tb_fix2single_arb.sv
// Randomized bench for fix2single_arb against a capacity-2 in-order buffer
// model with round-robin grants and a real-number conversion reference.
module tb_fix2single_arb;

  localparam int unsigned INT_W   = 12;
  localparam int unsigned FRACT_W = 4;
  localparam int unsigned W       = INT_W + FRACT_W;

  typedef struct {
    logic [W-1:0] op;
    logic         tag;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0;
  logic [W-1:0] req0_data = '0;
  logic         req0_ready;
  logic         req1_valid = 1'b0;
  logic [W-1:0] req1_data = '0;
  logic         req1_ready;
  logic         out_valid;
  logic [31:0]  out_data;
  logic         out_tag;
  logic         out_ready = 1'b0;

  int           cyc = 0;
  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic [31:0]  gold[$];
  exp_t         sb[$];
  logic         last_g = 1'b1;

  fix2single_arb #(
    .INT_WIDTH   (INT_W),
    .FRACT_WIDTH (FRACT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_tag    (out_tag),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Reference value: operand / 2^FRACT as a double, re-packed into single.
  function automatic logic [31:0] to_single(input logic [W-1:0] op);
    real         r;
    logic [63:0] b;
    if (op == '0) return 32'h0;
    r = real'(op) / (2.0 ** FRACT_W);
    b = $realtobits(r);
    return {1'b0, 8'(int'(b[62:52]) - 1023 + 127), b[51:29]};
  endfunction

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return '1;
      2:       return W'(1) << $urandom_range(0, W - 1);
      default: return W'($urandom);
    endcase
  endfunction

  task automatic step(input bit gap0, input bit gap1, input bit ordy, input bit rstv);
    logic any_exp;
    logic g;
    logic ov_exp;
    @(negedge clk);
    rst_n      = rstv;
    req0_valid = (q0.size() > 0) && !gap0;
    req0_data  = (q0.size() > 0) ? q0[0] : W'($urandom);
    req1_valid = (q1.size() > 0) && !gap1;
    req1_data  = (q1.size() > 0) ? q1[0] : W'($urandom);
    out_ready  = ordy;
    #1;
    if (!rst_n) begin
      sb.delete();
      gold.delete();
      last_g = 1'b1;
      check("rst_out_data", out_data, 32'h0);
      check("rst_out_tag", 32'(out_tag), 32'h0);
    end
    // Buffer of two results; it accepts whenever not full or being drained.
    any_exp = rst_n && (req0_valid || req1_valid) && (ordy || sb.size() < 2);
    g       = (req0_valid && req1_valid) ? !last_g : req1_valid;
    check("req0_ready", 32'(req0_ready), 32'(any_exp && !g));
    check("req1_ready", 32'(req1_ready), 32'(any_exp && g));
    ov_exp = rst_n && (sb.size() > 0) && (cyc >= sb[0].acc + 1);
    check("out_valid", 32'(out_valid), 32'(ov_exp));
    if (ov_exp && out_valid) begin
      check("out_data", out_data, to_single(sb[0].op));
      check("out_tag", 32'(out_tag), 32'(sb[0].tag));
      if (ordy) begin
        if (gold.size() > 0) check("golden_data", out_data, gold.pop_front());
        void'(sb.pop_front());
      end
    end
    if (rst_n && req0_valid && req0_ready) begin
      sb.push_back('{op: req0_data, tag: 1'b0, acc: cyc + 1});
      void'(q0.pop_front());
      last_g = 1'b0;
    end
    if (rst_n && req1_valid && req1_ready) begin
      sb.push_back('{op: req1_data, tag: 1'b1, acc: cyc + 1});
      void'(q1.pop_front());
      last_g = 1'b1;
    end
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      if (q0.size() < 3 && $urandom_range(0, 1) == 1) q0.push_back(rand_op());
      if (q1.size() < 3 && $urandom_range(0, 1) == 1) q1.push_back(rand_op());
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) != 0, 1'b1);
    end
    repeat (20) step(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    // Contention from reset: requester 0 first, then strict alternation.
    q0 = {16'hFFFF, 16'hFFFF};
    q1 = {16'h0000, 16'h0000};
    repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0);
    gold = {32'h457FFF00, 32'h00000000, 32'h457FFF00, 32'h00000000};
    repeat (10) step(1'b0, 1'b0, 1'b1, 1'b1);

    // Single operand, fixed two-cycle latency.
    q0.push_back(16'h0010);
    gold.push_back(32'h3F800000);
    repeat (5) step(1'b0, 1'b0, 1'b1, 1'b1);

    // Back-to-back from requester 1.
    q1.push_back(16'h0018);
    q1.push_back(16'h0001);
    gold.push_back(32'h3FC00000);
    gold.push_back(32'h3D800000);
    repeat (6) step(1'b0, 1'b0, 1'b1, 1'b1);

    // Consumer stall with both requesters busy, then in-order drain.
    repeat (3) begin
      q0.push_back(rand_op());
      q1.push_back(rand_op());
    end
    repeat (5) step(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (12) step(1'b0, 1'b0, 1'b1, 1'b1);

    random_phase(400);

    // Fill both stages, then reset mid-flight; nothing may surface afterwards.
    q0.push_back(rand_op());
    q1.push_back(rand_op());
    repeat (4) step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (6) step(1'b0, 1'b0, 1'b1, 1'b1);

    random_phase(300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fix2single_arb.md
FIX2SINGLE_ARB -- requirements
Module: fix2single_arb

Interface
Parameters:
REQ-001 SHALL provide parameter INT_WIDTH, default 12, integer bits of the unsigned fixed-point operand.
REQ-002 SHALL provide parameter FRACT_WIDTH, default 4, fractional bits of the operand; W = INT_WIDTH+FRACT_WIDTH, legal range 2..24.

Ports (clock and reset first):
REQ-003 SHALL have: clk  input  1  sole clock, rising edge.
REQ-004 SHALL have: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have: req0_valid  input  1  requester 0 operand valid.
REQ-006 SHALL have: req0_data  input  W  requester 0 unsigned fixed-point operand.
REQ-007 SHALL have: req0_ready  output  1  requester 0 operand accepted this cycle.
REQ-008 SHALL have: req1_valid, req1_data, req1_ready  same as requester 0.
REQ-009 SHALL have: out_valid  output  1  result valid.
REQ-010 SHALL have: out_data  output  32  IEEE 754 single result.
REQ-011 SHALL have: out_tag  output  1  index of the requester that owns out_data.
REQ-012 SHALL have: out_ready  input  1  consumer accepts result.

Function
REQ-013 Transfer on a port SHALL occur when valid and ready are both high at a rising clk edge; the consumer side transfers on out_valid && out_ready.
REQ-014 Datapath SHALL be two register stages: S1 (operand, tag, leading-zero count), S2 (assembled float, tag); out_valid/out_data/out_tag SHALL be driven directly from S2.
REQ-015 Latency SHALL be exactly 2 cycles from request transfer to out_valid when out_ready stays high; sustained throughput SHALL be one result per cycle.
REQ-016 S2 SHALL load when empty or when its content transfers out; otherwise S2 and, if full, S1 SHALL hold unchanged (stall).
REQ-017 S1 SHALL accept a new operand only when empty or advancing into S2 in the same cycle.
REQ-018 reqN_ready SHALL be high only for the granted requester and only when S1 can accept; ready SHALL NOT depend combinationally on out_ready beyond REQ-016/017.
REQ-019 Arbitration SHALL be round-robin with a 1-bit last-grant pointer: with both valid, grant the requester not last granted; with one valid, grant it.
REQ-020 The pointer SHALL update only on an actual request transfer.
REQ-021 At most one requester SHALL be accepted per cycle; the loser's ready SHALL be low.
REQ-022 Conversion: operand 0 SHALL produce 32'h00000000.
REQ-023 Non-zero operand with lz leading zeros SHALL produce sign 0, exponent 127+(INT_WIDTH-1-lz), mantissa = operand bits below the leading one, left-aligned in 23 bits, zero-filled (no rounding).
REQ-024 Stage results SHALL carry the tag so results emerge in acceptance order with correct out_tag.
REQ-025 A requester dropping valid without a transfer SHALL have no effect on the pipeline or pointer.

Reset
REQ-026 On rst_n low, S1 and S2 valid flags SHALL clear immediately; out_valid, out_data, out_tag, req0_ready and req1_ready SHALL be 0.
REQ-027 The last-grant pointer SHALL reset to 1 so requester 0 wins the first contention.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight results; no result SHALL appear after release until a new transfer.

Structure
REQ-029 A shared package SHALL hold constants FLOAT_BIAS (127), MANT_WIDTH (23), EXP_WIDTH (8) and the stage-record typedef (valid, tag, payload).
REQ-030 Conversion logic SHALL sit in one combinational sub-module fix2single_core (leading-zero count plus assembly), split across S1/S2 by the top level.

Verification (INT_WIDTH=12, FRACT_WIDTH=4)
REQ-031 req0 0x0010, out_ready=1 -> two cycles later out_valid=1, out_data=0x3F800000, out_tag=0.
REQ-032 req1 0x0018 then 0x0001 back-to-back -> 0x3FC00000 then 0x3D800000 on consecutive cycles, tag 1.
REQ-033 req0 0xFFFF, req1 0x0000, both held valid from reset -> req0 first (0x457FFF00, tag 0), then req1 (0x00000000, tag 1); grants alternate.
REQ-034 out_ready=0 for 5 cycles with both requesters valid -> at most 2 accepted, out_data stable, no loss; release gives in-order drain.
REQ-035 rst_n pulsed low while S1 and S2 are full -> out_valid drops asynchronously; no stale result after release.
